// File: rtl/keypad_lock_pkg.sv
// Shared types and constants for the keypad lock: state encoding,
// raw keypad scan codes, tone selection and key decode helpers.
package keypad_lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY    = 2'b00,
    ST_UNLOCKED = 2'b01,
    ST_LOCKOUT  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    TONE_KEY = 2'd0,
    TONE_OK  = 2'd1,
    TONE_BAD = 2'd2
  } tone_e;

  typedef enum logic [1:0] {
    K_DIGIT  = 2'd0,
    K_ENTER  = 2'd1,
    K_CLEAR  = 2'd2,
    K_MASTER = 2'd3
  } key_kind_e;

  typedef struct packed {
    logic      valid;
    key_kind_e kind;
    logic [3:0] digit;
  } key_t;

  localparam logic [3:0] BLANK = 4'hF;

  // All sixteen keypad positions; three of them carry no function.
  localparam logic [15:0] KEY_ENTER  = 16'h0001;
  localparam logic [15:0] KEY_NC_A   = 16'h0002;
  localparam logic [15:0] KEY_NC_B   = 16'h0004;
  localparam logic [15:0] KEY_0      = 16'h0008;
  localparam logic [15:0] KEY_NC_C   = 16'h0010;
  localparam logic [15:0] KEY_3      = 16'h0020;
  localparam logic [15:0] KEY_2      = 16'h0040;
  localparam logic [15:0] KEY_1      = 16'h0080;
  localparam logic [15:0] KEY_MASTER = 16'h0100;
  localparam logic [15:0] KEY_6      = 16'h0200;
  localparam logic [15:0] KEY_5      = 16'h0400;
  localparam logic [15:0] KEY_4      = 16'h0800;
  localparam logic [15:0] KEY_CLEAR  = 16'h1000;
  localparam logic [15:0] KEY_9      = 16'h2000;
  localparam logic [15:0] KEY_8      = 16'h4000;
  localparam logic [15:0] KEY_7      = 16'h8000;

  // Map a scan code to a key; anything unmapped (incl. multi-hot) is no key.
  function automatic key_t decode_key(input logic [15:0] oh);
    key_t k;
    k = '{valid: 1'b1, kind: K_DIGIT, digit: 4'd0};
    case (oh)
      KEY_0:      k.digit = 4'd0;
      KEY_1:      k.digit = 4'd1;
      KEY_2:      k.digit = 4'd2;
      KEY_3:      k.digit = 4'd3;
      KEY_4:      k.digit = 4'd4;
      KEY_5:      k.digit = 4'd5;
      KEY_6:      k.digit = 4'd6;
      KEY_7:      k.digit = 4'd7;
      KEY_8:      k.digit = 4'd8;
      KEY_9:      k.digit = 4'd9;
      KEY_ENTER:  k.kind  = K_ENTER;
      KEY_CLEAR:  k.kind  = K_CLEAR;
      KEY_MASTER: k.kind  = K_MASTER;
      default:    k.valid = 1'b0;
    endcase
    return k;
  endfunction

  // Two-digit BCD decrement with borrow from the tens digit.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/lock_buzzer.sv
// Tone generator: square wave of a selected half-period for a selected
// length, restarted by every start pulse; BAD tone is muted in its middle third.
module lock_buzzer
  import keypad_lock_pkg::*;
#(
  parameter int unsigned KEY_HP  = 50000,
  parameter int unsigned OK_HP   = 25000,
  parameter int unsigned BAD_HP  = 100000,
  parameter int unsigned KEY_LEN = 10000000,
  parameter int unsigned OK_LEN  = 30000000,
  parameter int unsigned BAD_LEN = 15000000
) (
  input  logic  clk,
  input  logic  RSTn,
  input  logic  start,
  input  tone_e sel,
  output logic  buzzer
);

  tone_e       sel_q;
  logic        active, phase, mute;
  int unsigned hp_cnt, len_cnt, hp_lim, len_lim;

  // Limits of the tone currently playing.
  always_comb begin
    hp_lim  = KEY_HP;
    len_lim = KEY_LEN;
    case (sel_q)
      TONE_OK:  begin hp_lim = OK_HP;  len_lim = OK_LEN;  end
      TONE_BAD: begin hp_lim = BAD_HP; len_lim = BAD_LEN; end
      default:  ;
    endcase
    mute = (sel_q == TONE_BAD) && (len_cnt >= BAD_LEN / 3) && (len_cnt < (2 * BAD_LEN) / 3);
  end

  // Tone timers; a start always reloads from the beginning, high phase first.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      sel_q   <= TONE_KEY;
      active  <= 1'b0;
      phase   <= 1'b0;
      hp_cnt  <= 0;
      len_cnt <= 0;
    end else if (start) begin
      sel_q   <= sel;
      active  <= 1'b1;
      phase   <= 1'b1;
      hp_cnt  <= 0;
      len_cnt <= 0;
    end else if (active) begin
      if (len_cnt == len_lim - 1) begin
        active  <= 1'b0;
        phase   <= 1'b0;
        len_cnt <= 0;
        hp_cnt  <= 0;
      end else begin
        len_cnt <= len_cnt + 1;
        if (hp_cnt == hp_lim - 1) begin
          hp_cnt <= 0;
          phase  <= ~phase;
        end else begin
          hp_cnt <= hp_cnt + 1;
        end
      end
    end
  end

  assign buzzer = active & phase & ~mute;

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad combination lock: edge-detected key presses feed an
// ENTRY / UNLOCKED / LOCKOUT controller with a BCD lockout countdown.
module keypad_lock_ctrl
  import keypad_lock_pkg::*;
#(
  parameter int          N_DIGITS     = 4,
  parameter logic [4*N_DIGITS-1:0] PASSWORD = 16'h2460,
  parameter int          MAX_TRIES    = 3,
  parameter int          LOCK_SECONDS = 20,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned KEY_HP       = 50000,
  parameter int unsigned OK_HP        = 25000,
  parameter int unsigned BAD_HP       = 100000,
  parameter int unsigned KEY_LEN      = CLK_HZ / 5,
  parameter int unsigned OK_LEN       = 3 * CLK_HZ / 5,
  parameter int unsigned BAD_LEN      = 3 * CLK_HZ / 10,
  localparam int         CW           = $clog2(N_DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  RSTn,
  input  logic [15:0]           onehot,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [CW-1:0]         count,
  output logic [1:0]            state,
  output logic [3:0]            tries,
  output logic [7:0]            lock_bcd,
  output logic                  buzzer
);

  localparam logic [CW-1:0]         FULL      = CW'(N_DIGITS);
  localparam logic [3:0]            MAX_T     = 4'(MAX_TRIES);
  localparam logic [7:0]            LOCK_INIT = {4'(LOCK_SECONDS / 10), 4'(LOCK_SECONDS % 10)};
  localparam logic [4*N_DIGITS-1:0] BLANKS    = {N_DIGITS{BLANK}};

  state_e      st;
  logic [15:0] prev_oh;
  logic        press_q;
  key_kind_e   kind_q;
  logic [3:0]  digit_q;
  logic [31:0] presc;
  key_t        cur_key, prev_key;
  logic        tone_start, full_entry;
  tone_e       tone_sel;
  logic [3:0]  tries_inc;

  assign cur_key   = decode_key(onehot);
  assign prev_key  = decode_key(prev_oh);
  assign state     = st;
  assign tries_inc = tries + 4'd1;
  assign full_entry = press_q && (st == ST_ENTRY) && (kind_q == K_ENTER) && (count == FULL);

  // Detect the rising edge of a mapped key and hold it for one cycle.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      prev_oh <= '0;
      press_q <= 1'b0;
      kind_q  <= K_DIGIT;
      digit_q <= 4'd0;
    end else begin
      prev_oh <= onehot;
      press_q <= cur_key.valid && !prev_key.valid;
      kind_q  <= cur_key.kind;
      digit_q <= cur_key.digit;
    end
  end

  // Every press beeps; a completed entry overrides with the verdict tone.
  always_comb begin
    tone_start = press_q;
    tone_sel   = TONE_KEY;
    if (full_entry) tone_sel = (digits == PASSWORD) ? TONE_OK : TONE_BAD;
  end

  // Main lock FSM, including the lockout prescaler and countdown.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      st       <= ST_ENTRY;
      digits   <= BLANKS;
      count    <= '0;
      tries    <= 4'd0;
      lock_bcd <= 8'h00;
      presc    <= '0;
    end else begin
      case (st)
        ST_ENTRY, ST_UNLOCKED: begin
          presc <= '0;
          if (press_q) begin
            case (kind_q)
              K_CLEAR, K_MASTER: begin
                digits <= BLANKS;
                count  <= '0;
                st     <= ST_ENTRY;
                if (kind_q == K_MASTER) tries <= 4'd0;
              end
              K_DIGIT: if (st == ST_ENTRY && count < FULL) begin
                digits <= {digits[4*N_DIGITS-5:0], digit_q};
                count  <= count + CW'(1);
              end
              K_ENTER: if (full_entry) begin
                if (digits == PASSWORD) begin
                  st <= ST_UNLOCKED;
                end else begin
                  digits <= BLANKS;
                  count  <= '0;
                  if (tries_inc == MAX_T) begin
                    st       <= ST_LOCKOUT;
                    tries    <= 4'd0;
                    lock_bcd <= LOCK_INIT;
                  end else begin
                    tries <= tries_inc;
                  end
                end
              end
              default: ;
            endcase
          end
        end
        ST_LOCKOUT: begin
          if (presc == 32'(CLK_HZ - 1)) begin
            presc <= '0;
            if (lock_bcd == 8'h01) begin
              lock_bcd <= 8'h00;
              st       <= ST_ENTRY;
            end else begin
              lock_bcd <= bcd_dec(lock_bcd);
            end
          end else begin
            presc <= presc + 32'd1;
          end
        end
        default: st <= ST_ENTRY;
      endcase
    end
  end

  lock_buzzer #(
    .KEY_HP(KEY_HP), .OK_HP(OK_HP), .BAD_HP(BAD_HP),
    .KEY_LEN(KEY_LEN), .OK_LEN(OK_LEN), .BAD_LEN(BAD_LEN)
  ) u_buzzer (
    .clk    (clk),
    .RSTn   (RSTn),
    .start  (tone_start),
    .sel    (tone_sel),
    .buzzer (buzzer)
  );

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Directed bench for keypad_lock_ctrl with a 1 kHz "second" and short tones.
module tb_keypad_lock_ctrl;

  localparam int KHP = 4, OHP = 2, BHP = 6, KLEN = 20, OLEN = 30, BLEN = 30;

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic [15:0] onehot = '0;
  logic [15:0] digits;
  logic [2:0]  count;
  logic [1:0]  state;
  logic [3:0]  tries;
  logic [7:0]  lock_bcd;
  logic        buzzer;
  int checks = 0;
  int errors = 0;

  keypad_lock_ctrl #(
    .CLK_HZ(1000), .KEY_HP(KHP), .OK_HP(OHP), .BAD_HP(BHP),
    .KEY_LEN(KLEN), .OK_LEN(OLEN), .BAD_LEN(BLEN)
  ) dut (
    .clk(clk), .RSTn(RSTn), .onehot(onehot), .digits(digits), .count(count),
    .state(state), .tries(tries), .lock_bcd(lock_bcd), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  // Expected buzzer level k cycles after a tone starts.
  function automatic logic exp_buz(input int k, input int hp, input int len, input bit bad);
    if (k >= len) return 1'b0;
    if (bad && k >= len / 3 && k < (2 * len) / 3) return 1'b0;
    return ((k / hp) % 2) == 0;
  endfunction

  // One clean press: key visible for one edge, effect visible at return.
  task automatic press(input logic [15:0] code);
    @(negedge clk) onehot = code;
    @(negedge clk) onehot = '0;
    @(negedge clk);
  endtask

  task automatic enter_code(input logic [15:0] a, b, c, d);
    press(a); press(b); press(c); press(d); press(16'h0001);
  endtask

  task automatic test_reset;
    RSTn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'b00)      begin errors++; $display("FAIL reset_state got %h want 0", state); end
    checks++; if (digits !== 16'hFFFF)  begin errors++; $display("FAIL reset_digits got %h want ffff", digits); end
    checks++; if (count !== 3'd0)       begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (tries !== 4'd0)       begin errors++; $display("FAIL reset_tries got %0d want 0", tries); end
    checks++; if (lock_bcd !== 8'h00)   begin errors++; $display("FAIL reset_lock got %h want 00", lock_bcd); end
    checks++; if (buzzer !== 1'b0)      begin errors++; $display("FAIL reset_buzzer got %b want 0", buzzer); end
    RSTn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unlock;
    press(16'h0040);
    checks++; if (digits !== 16'hFFF2) begin errors++; $display("FAIL unlock_d1 got %h want fff2", digits); end
    press(16'h0800); press(16'h0200);
    checks++; if (digits !== 16'hF246) begin errors++; $display("FAIL unlock_d3 got %h want f246", digits); end
    press(16'h0008);
    checks++; if (digits !== 16'h2460 || count !== 3'd4) begin errors++; $display("FAIL unlock_d4 got %h/%0d want 2460/4", digits, count); end
    press(16'h0001);
    checks++; if (state !== 2'b01)     begin errors++; $display("FAIL unlock_state got %h want 1", state); end
    checks++; if (digits !== 16'h2460) begin errors++; $display("FAIL unlock_keep got %h want 2460", digits); end
    for (int k = 0; k <= OLEN + 1; k++) begin
      checks++;
      if (buzzer !== exp_buz(k, OHP, OLEN, 1'b0)) begin errors++; $display("FAIL ok_tone k=%0d got %b want %b", k, buzzer, exp_buz(k, OHP, OLEN, 1'b0)); end
      @(negedge clk);
    end
    press(16'h0080);
    checks++; if (state !== 2'b01 || digits !== 16'h2460) begin errors++; $display("FAIL unlocked_ign got %h/%h want 1/2460", state, digits); end
    press(16'h1000);
    checks++; if (state !== 2'b00 || digits !== 16'hFFFF || count !== 3'd0) begin errors++; $display("FAIL unlock_clear got %h/%h/%0d want 0/ffff/0", state, digits, count); end
  endtask

  task automatic test_key_tone;
    press(16'h8000);
    for (int k = 0; k <= KLEN + 1; k++) begin
      checks++;
      if (buzzer !== exp_buz(k, KHP, KLEN, 1'b0)) begin errors++; $display("FAIL key_tone k=%0d got %b want %b", k, buzzer, exp_buz(k, KHP, KLEN, 1'b0)); end
      @(negedge clk);
    end
    press(16'h1000);
  endtask

  task automatic test_hold;
    @(negedge clk) onehot = 16'h0400;
    repeat (100) @(negedge clk);
    onehot = '0;
    @(negedge clk);
    checks++; if (count !== 3'd1 || digits !== 16'hFFF5) begin errors++; $display("FAIL hold got %0d/%h want 1/fff5", count, digits); end
    // Slide straight from 5 to 6: only the first code counts.
    @(negedge clk) onehot = 16'h0400;
    @(negedge clk) onehot = 16'h0200;
    @(negedge clk) onehot = '0;
    @(negedge clk);
    checks++; if (count !== 3'd2 || digits !== 16'hFF55) begin errors++; $display("FAIL slide got %0d/%h want 2/ff55", count, digits); end
    press(16'h0400); press(16'h0400);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill got %0d want 4", count); end
    press(16'h0400);
    checks++; if (count !== 3'd4 || digits !== 16'h5555) begin errors++; $display("FAIL fifth got %0d/%h want 4/5555", count, digits); end
    press(16'h1000);
    press(16'h0400); press(16'h0400); press(16'h0400); press(16'h0001);
    checks++; if (count !== 3'd3 || state !== 2'b00 || tries !== 4'd0 || digits !== 16'hF555) begin errors++; $display("FAIL short_enter got %0d/%h/%0d/%h want 3/0/0/f555", count, state, tries, digits); end
    press(16'h1000);
  endtask

  task automatic test_master_clear;
    enter_code(16'h0080, 16'h0080, 16'h0080, 16'h0080);
    checks++; if (tries !== 4'd1 || digits !== 16'hFFFF || count !== 3'd0) begin errors++; $display("FAIL fail1 got %0d/%h/%0d want 1/ffff/0", tries, digits, count); end
    for (int k = 0; k <= BLEN + 1; k++) begin
      checks++;
      if (buzzer !== exp_buz(k, BHP, BLEN, 1'b1)) begin errors++; $display("FAIL bad_tone k=%0d got %b want %b", k, buzzer, exp_buz(k, BHP, BLEN, 1'b1)); end
      @(negedge clk);
    end
    press(16'h0040);
    press(16'h0100);
    checks++; if (tries !== 4'd0 || digits !== 16'hFFFF || count !== 3'd0) begin errors++; $display("FAIL master got %0d/%h/%0d want 0/ffff/0", tries, digits, count); end
    enter_code(16'h0080, 16'h0080, 16'h0080, 16'h0080);
    press(16'h0040);
    press(16'h1000);
    checks++; if (tries !== 4'd1 || digits !== 16'hFFFF) begin errors++; $display("FAIL clear_keeps got %0d/%h want 1/ffff", tries, digits); end
    press(16'h0100);
  endtask

  task automatic test_lockout;
    int t;
    enter_code(16'h0080, 16'h0080, 16'h0080, 16'h0080);
    checks++; if (tries !== 4'd1) begin errors++; $display("FAIL lk_t1 got %0d want 1", tries); end
    enter_code(16'h0080, 16'h0080, 16'h0080, 16'h0080);
    checks++; if (tries !== 4'd2) begin errors++; $display("FAIL lk_t2 got %0d want 2", tries); end
    enter_code(16'h0080, 16'h0080, 16'h0080, 16'h0080);
    t = 0;
    checks++; if (state !== 2'b10 || lock_bcd !== 8'h20 || tries !== 4'd0 || digits !== 16'hFFFF) begin errors++; $display("FAIL lk_enter got %h/%h/%0d/%h want 2/20/0/ffff", state, lock_bcd, tries, digits); end
    repeat (100) @(negedge clk); t += 100;
    press(16'h0040); t += 3;
    checks++; if (digits !== 16'hFFFF || count !== 3'd0 || state !== 2'b10 || buzzer !== 1'b1) begin errors++; $display("FAIL lk_press got %h/%0d/%h/%b want ffff/0/2/1", digits, count, state, buzzer); end
    press(16'h0100); t += 3;
    checks++; if (state !== 2'b10 || lock_bcd !== 8'h20) begin errors++; $display("FAIL lk_master got %h/%h want 2/20", state, lock_bcd); end
    repeat (999 - t) @(negedge clk); t = 999;
    checks++; if (lock_bcd !== 8'h20) begin errors++; $display("FAIL lk_999 got %h want 20", lock_bcd); end
    @(negedge clk); t = 1000;
    checks++; if (lock_bcd !== 8'h19) begin errors++; $display("FAIL lk_1000 got %h want 19", lock_bcd); end
    repeat (10999 - t) @(negedge clk); t = 10999;
    checks++; if (lock_bcd !== 8'h10) begin errors++; $display("FAIL lk_10 got %h want 10", lock_bcd); end
    @(negedge clk); t = 11000;
    checks++; if (lock_bcd !== 8'h09) begin errors++; $display("FAIL lk_borrow got %h want 09", lock_bcd); end
    repeat (19999 - t) @(negedge clk); t = 19999;
    checks++; if (state !== 2'b10 || lock_bcd !== 8'h01) begin errors++; $display("FAIL lk_last got %h/%h want 2/01", state, lock_bcd); end
    @(negedge clk);
    checks++; if (state !== 2'b00 || lock_bcd !== 8'h00) begin errors++; $display("FAIL lk_exit got %h/%h want 0/00", state, lock_bcd); end
    press(16'h0800);
    checks++; if (digits !== 16'hFFF4 || count !== 3'd1) begin errors++; $display("FAIL lk_after got %h/%0d want fff4/1", digits, count); end
    press(16'h1000);
  endtask

  task automatic test_reset_mid;
    enter_code(16'h0080, 16'h0080, 16'h0080, 16'h0080);
    enter_code(16'h0080, 16'h0080, 16'h0080, 16'h0080);
    enter_code(16'h0080, 16'h0080, 16'h0080, 16'h0080);
    repeat (1500) @(negedge clk);
    press(16'h0040);
    checks++; if (state !== 2'b10 || lock_bcd !== 8'h19 || buzzer !== 1'b1) begin errors++; $display("FAIL mid_pre got %h/%h/%b want 2/19/1", state, lock_bcd, buzzer); end
    RSTn = 1'b0;
    @(negedge clk);
    checks++; if (state !== 2'b00 || digits !== 16'hFFFF || count !== 3'd0 || tries !== 4'd0 || lock_bcd !== 8'h00 || buzzer !== 1'b0) begin
      errors++; $display("FAIL mid_reset got %h/%h/%0d/%0d/%h/%b want 0/ffff/0/0/00/0", state, digits, count, tries, lock_bcd, buzzer);
    end
    RSTn = 1'b1;
    repeat (1200) @(negedge clk);
    checks++; if (state !== 2'b00 || lock_bcd !== 8'h00) begin errors++; $display("FAIL post_reset got %h/%h want 0/00", state, lock_bcd); end
  endtask

  initial begin
    test_reset;
    test_unlock;
    test_key_tone;
    test_hold;
    test_master_clear;
    test_lockout;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
